// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: instruction and data requesters share one memory port.
// At most one transaction is in flight; the response is routed back to the port that was granted.
module mem_arbiter #(
    parameter int unsigned RR_EN = 1
) (
    input  logic        clk,
    input  logic        res,

    input  logic        instr_req,
    input  logic [31:0] instr_adr,
    output logic        instr_gnt,
    output logic        instr_rvalid,
    output logic [31:0] instr_read,

    input  logic        data_req,
    input  logic [31:0] data_adr,
    input  logic        data_we,
    input  logic [3:0]  data_be,
    input  logic [31:0] data_wdata,
    output logic        data_gnt,
    output logic        data_rvalid,
    output logic [31:0] data_read,

    output logic        mem_req,
    output logic [31:0] mem_adr,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_read
);

    typedef enum logic [0:0] {StIdle, StWait} state_e;

    state_e state_q, state_d;
    // Side encodings below: 1 = data port, 0 = instruction port.
    logic   owner_q, owner_d;
    logic   last_q, last_d;
    logic   lock_q, lock_d;
    logic   lock_side_q, lock_side_d;
    logic   pick;

    always_comb begin
        // A winner left waiting for mem_gnt keeps the bus while it still requests.
        if (lock_q && (lock_side_q ? data_req : instr_req)) begin
            pick = lock_side_q;
        end else if (instr_req && data_req) begin
            pick = (RR_EN != 0) ? ~last_q : 1'b1;
        end else begin
            pick = data_req;
        end
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_d       = last_q;
        lock_d       = lock_q;
        lock_side_d  = lock_side_q;
        instr_gnt    = 1'b0;
        instr_rvalid = 1'b0;
        instr_read   = '0;
        data_gnt     = 1'b0;
        data_rvalid  = 1'b0;
        data_read    = '0;
        mem_req      = 1'b0;
        mem_adr      = '0;
        mem_we       = 1'b0;
        mem_be       = '0;
        mem_wdata    = '0;

        case (state_q)
            StIdle: begin
                if (instr_req || data_req) begin
                    mem_req = 1'b1;
                    if (pick) begin
                        mem_adr   = data_adr;
                        mem_we    = data_we;
                        mem_be    = data_be;
                        mem_wdata = data_wdata;
                        data_gnt  = mem_gnt;
                    end else begin
                        mem_adr   = instr_adr;
                        mem_be    = 4'hF;
                        instr_gnt = mem_gnt;
                    end
                    if (mem_gnt) begin
                        state_d = StWait;
                        owner_d = pick;
                        last_d  = pick;
                        lock_d  = 1'b0;
                    end else begin
                        lock_d      = 1'b1;
                        lock_side_d = pick;
                    end
                end
            end
            StWait: begin
                if (mem_rvalid) begin
                    if (owner_q) begin
                        data_rvalid = 1'b1;
                        data_read   = mem_read;
                    end else begin
                        instr_rvalid = 1'b1;
                        instr_read   = mem_read;
                    end
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (res) begin
            state_q     <= StIdle;
            owner_q     <= 1'b0;
            last_q      <= 1'b1;
            lock_q      <= 1'b0;
            lock_side_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            lock_q      <= lock_d;
            lock_side_q <= lock_side_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomised bench for mem_arbiter: one round-robin and one fixed-priority instance, each driven by
// its own requester/memory model, with every cycle's expected outputs queued and compared.
module tb_mem_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        res          [2];
    logic        instr_req    [2];
    logic [31:0] instr_adr    [2];
    logic        instr_gnt    [2];
    logic        instr_rvalid [2];
    logic [31:0] instr_read   [2];
    logic        data_req     [2];
    logic [31:0] data_adr     [2];
    logic        data_we      [2];
    logic [3:0]  data_be      [2];
    logic [31:0] data_wdata   [2];
    logic        data_gnt     [2];
    logic        data_rvalid  [2];
    logic [31:0] data_read    [2];
    logic        mem_req      [2];
    logic [31:0] mem_adr      [2];
    logic        mem_we       [2];
    logic [3:0]  mem_be       [2];
    logic [31:0] mem_wdata    [2];
    logic        mem_gnt      [2];
    logic        mem_rvalid   [2];
    logic [31:0] mem_read     [2];

    // Instance 0 is round-robin, instance 1 is fixed priority (data wins).
    for (genvar g = 0; g < 2; g++) begin : g_dut
        mem_arbiter #(
            .RR_EN(g == 0 ? 1 : 0)
        ) u_dut (
            .clk         (clk),
            .res         (res[g]),
            .instr_req   (instr_req[g]),
            .instr_adr   (instr_adr[g]),
            .instr_gnt   (instr_gnt[g]),
            .instr_rvalid(instr_rvalid[g]),
            .instr_read  (instr_read[g]),
            .data_req    (data_req[g]),
            .data_adr    (data_adr[g]),
            .data_we     (data_we[g]),
            .data_be     (data_be[g]),
            .data_wdata  (data_wdata[g]),
            .data_gnt    (data_gnt[g]),
            .data_rvalid (data_rvalid[g]),
            .data_read   (data_read[g]),
            .mem_req     (mem_req[g]),
            .mem_adr     (mem_adr[g]),
            .mem_we      (mem_we[g]),
            .mem_be      (mem_be[g]),
            .mem_wdata   (mem_wdata[g]),
            .mem_gnt     (mem_gnt[g]),
            .mem_rvalid  (mem_rvalid[g]),
            .mem_read    (mem_read[g])
        );
    end

    typedef struct packed {
        logic        mem_req;
        logic [31:0] mem_adr;
        logic        mem_we;
        logic [3:0]  mem_be;
        logic [31:0] mem_wdata;
        logic        instr_gnt;
        logic        data_gnt;
        logic        instr_rvalid;
        logic [31:0] instr_read;
        logic        data_rvalid;
        logic [31:0] data_read;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model: transaction-level view of each arbiter and its two requesters.
    bit          m_busy   [2];  // a transaction has been accepted and awaits its response
    int          m_owner  [2];  // 0 = instr, 1 = data
    int          m_prev   [2];  // side granted most recently
    int          m_held   [2];  // side stalled on mem_gnt, -1 if none
    bit          m_ireq   [2];
    logic [31:0] m_iadr   [2];
    bit          m_dreq   [2];
    logic [31:0] m_dadr   [2];
    logic        m_dwe    [2];
    logic [3:0]  m_dbe    [2];
    logic [31:0] m_dwdata [2];

    function automatic void push(input int k, input exp_t e);
        if (k == 0) q0.push_back(e);
        else        q1.push_back(e);
    endfunction

    task automatic new_data(input int k);
        m_dadr[k]   = $urandom;
        m_dwe[k]    = 1'($urandom_range(0, 1));
        m_dbe[k]    = 4'($urandom_range(0, 15));
        m_dwdata[k] = $urandom;
    endtask

    task automatic model_reset(input int k);
        m_busy[k] = 1'b0;
        m_prev[k] = 1;
        m_held[k] = -1;
        m_ireq[k] = 1'b0;
        m_dreq[k] = 1'b0;
    endtask

    task automatic step(input int k);
        exp_t e;
        int   win;
        e = '0;
        if ($urandom_range(0, 39) == 0) begin
            res[k]        = 1'b1;
            instr_req[k]  = 1'b0;
            data_req[k]   = 1'b0;
            mem_gnt[k]    = 1'b0;
            mem_rvalid[k] = 1'b0;
            mem_read[k]   = $urandom;
            model_reset(k);
            push(k, e);
            return;
        end
        res[k] = 1'b0;
        if (!m_ireq[k] && $urandom_range(0, 2) == 0) begin
            m_ireq[k] = 1'b1;
            m_iadr[k] = $urandom;
        end
        if (!m_dreq[k] && $urandom_range(0, 2) == 0) begin
            m_dreq[k] = 1'b1;
            new_data(k);
        end
        instr_req[k]  = m_ireq[k];
        instr_adr[k]  = m_iadr[k];
        data_req[k]   = m_dreq[k];
        data_adr[k]   = m_dadr[k];
        data_we[k]    = m_dwe[k];
        data_be[k]    = m_dbe[k];
        data_wdata[k] = m_dwdata[k];
        mem_read[k]   = $urandom;

        if (!m_busy[k]) begin
            mem_gnt[k]    = (m_ireq[k] || m_dreq[k]) && ($urandom_range(0, 1) == 1);
            mem_rvalid[k] = ($urandom_range(0, 3) == 0);  // stray response, must be ignored
            if (m_ireq[k] || m_dreq[k]) begin
                if (m_held[k] >= 0)            win = m_held[k];
                else if (!m_dreq[k])           win = 0;
                else if (!m_ireq[k])           win = 1;
                else if (k == 0)               win = 1 - m_prev[k];
                else                           win = 1;
                e.mem_req = 1'b1;
                if (win == 1) begin
                    e.mem_adr   = m_dadr[k];
                    e.mem_we    = m_dwe[k];
                    e.mem_be    = m_dbe[k];
                    e.mem_wdata = m_dwdata[k];
                    e.data_gnt  = mem_gnt[k];
                end else begin
                    e.mem_adr   = m_iadr[k];
                    e.mem_be    = 4'hF;
                    e.instr_gnt = mem_gnt[k];
                end
                if (mem_gnt[k]) begin
                    m_busy[k]  = 1'b1;
                    m_owner[k] = win;
                    m_prev[k]  = win;
                    m_held[k]  = -1;
                    // Granted requester either issues a fresh request or goes quiet.
                    if (win == 1) begin
                        if ($urandom_range(0, 1) == 1) new_data(k);
                        else m_dreq[k] = 1'b0;
                    end else begin
                        if ($urandom_range(0, 1) == 1) m_iadr[k] = $urandom;
                        else m_ireq[k] = 1'b0;
                    end
                end else begin
                    m_held[k] = win;
                end
            end
        end else begin
            mem_gnt[k]    = ($urandom_range(0, 3) == 0);
            mem_rvalid[k] = ($urandom_range(0, 1) == 1);
            if (mem_rvalid[k]) begin
                if (m_owner[k] == 1) begin
                    e.data_rvalid = 1'b1;
                    e.data_read   = mem_read[k];
                end else begin
                    e.instr_rvalid = 1'b1;
                    e.instr_read   = mem_read[k];
                end
                m_busy[k] = 1'b0;
            end
        end
        push(k, e);
    endtask

    // Monitor: every cycle with a queued expectation, compare the full output set mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                exp_t exp_v;
                exp_t act;
                bit   have;
                have = 1'b0;
                if (k == 0 && q0.size() > 0) begin
                    exp_v = q0.pop_front();
                    have  = 1'b1;
                end else if (k == 1 && q1.size() > 0) begin
                    exp_v = q1.pop_front();
                    have  = 1'b1;
                end
                if (have) begin
                    act = '{mem_req[k], mem_adr[k], mem_we[k], mem_be[k], mem_wdata[k],
                            instr_gnt[k], data_gnt[k], instr_rvalid[k], instr_read[k],
                            data_rvalid[k], data_read[k]};
                    checks++;
                    if (act !== exp_v) begin
                        errors++;
                        $display("FAIL outputs dut%0d t=%0t: got %h expected %h",
                                 k, $time, act, exp_v);
                    end
                end
            end
        end
    end

    initial begin
        for (int k = 0; k < 2; k++) begin
            res[k]        = 1'b1;
            instr_req[k]  = 1'b0;
            instr_adr[k]  = '0;
            data_req[k]   = 1'b0;
            data_adr[k]   = '0;
            data_we[k]    = 1'b0;
            data_be[k]    = '0;
            data_wdata[k] = '0;
            mem_gnt[k]    = 1'b0;
            mem_rvalid[k] = 1'b0;
            mem_read[k]   = '0;
            m_iadr[k]     = '0;
            model_reset(k);
            new_data(k);
        end
        repeat (2) @(posedge clk);
        #1;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            for (int k = 0; k < 2; k++) step(k);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        #1;
        checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d/%0d pending expected 0/0", q0.size(), q1.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter RR_EN, default 1, meaning 1 = round-robin arbitration and 0 = fixed priority with the data port winning.
REQ-002 SHALL use one clock, clk; reset is res, synchronous and active-high.
REQ-003 clk  in  1  system clock, all state updates on the rising edge.
REQ-004 res  in  1  synchronous active-high reset.
REQ-005 instr_req  in  1  instruction-side request.
REQ-006 instr_adr  in  32  instruction-side address.
REQ-007 instr_gnt  out  1  instruction request accepted.
REQ-008 instr_rvalid  out  1  instruction read data valid.
REQ-009 instr_read  out  32  instruction read data.
REQ-010 data_req  in  1  data-side request.
REQ-011 data_adr  in  32  data-side address.
REQ-012 data_we  in  1  data-side write enable.
REQ-013 data_be  in  4  data-side byte enables.
REQ-014 data_wdata  in  32  data-side write data.
REQ-015 data_gnt  out  1  data request accepted.
REQ-016 data_rvalid  out  1  data response valid, for reads and writes.
REQ-017 data_read  out  32  data read data.
REQ-018 mem_req, mem_adr[32], mem_we, mem_be[4], mem_wdata[32]  out  request to main memory.
REQ-019 mem_gnt  in  1, mem_rvalid  in  1, mem_read  in  32  response from main memory.

Function
REQ-020 SHALL have states IDLE and WAIT; at most one memory transaction is outstanding at any time.
REQ-021 IDLE, no request pending: mem_req=0, all mem_* fields 0, both gnt signals 0.
REQ-022 IDLE, at least one request pending: select a winner, drive mem_req=1 and the winner's adr/we/be/wdata, and drive winner_gnt=mem_gnt combinationally; the loser's gnt is 0.
REQ-023 Instruction-side requests SHALL drive mem_we=0, mem_be=4'hF and mem_wdata=0.
REQ-024 Only one requester: that requester wins.
REQ-025 Both requesters, RR_EN=1: the requester not granted last wins.
REQ-026 Both requesters, RR_EN=0: data wins.
REQ-027 Lock: once mem_req is asserted for a winner without mem_gnt, that winner SHALL stay selected every cycle until mem_gnt, even if the other side raises req.
REQ-028 IDLE with mem_req=1 and mem_gnt=1: register owner=winner, update last_grant=winner, clear the lock, and go to WAIT on the next edge.
REQ-029 WAIT: mem_req=0 and both gnt signals 0.
REQ-030 WAIT with mem_rvalid=1: owner_rvalid=1 and owner_read=mem_read in the same cycle (combinational, zero added latency); return to IDLE on the next edge.
REQ-031 The non-owner's rvalid SHALL be 0, and its read SHALL be 0.
REQ-032 instr_read and data_read SHALL be 0 whenever their rvalid is 0.
REQ-033 mem_rvalid while in IDLE SHALL be ignored: no rvalid is forwarded and no state changes.
REQ-034 Back-to-back: in the cycle after the WAIT-to-IDLE transition, a new request SHALL be arbitrated; minimum spacing between two grants is 2 cycles.
REQ-035 Requesters SHALL hold req and their fields stable until gnt; the arbiter registers no request fields.

Reset
REQ-036 When res=1 at a clock edge: state=IDLE, owner cleared, lock cleared, last_grant=data (so instr wins the first tie when RR_EN=1).
REQ-037 All outputs SHALL be 0 in the cycle after reset while no request is pending.
REQ-038 Reset while in WAIT SHALL abandon the outstanding transaction; a mem_rvalid arriving later is ignored per REQ-033.

Verification
REQ-039 Reset, then instr_req=1 with instr_adr=0x100, mem_gnt=1 -> mem_adr=0x100, mem_we=0, instr_gnt=1 in the same cycle; mem_rvalid=1 with mem_read=0xDEADBEEF next cycle -> instr_rvalid=1, instr_read=0xDEADBEEF, data_rvalid=0.
REQ-040 RR_EN=1, both requesting continuously, mem_gnt=1 and rvalid one cycle later -> grants alternate instr, data, instr, data, starting with instr after reset.
REQ-041 RR_EN=0, both requesting -> data is granted every time while data_req stays high; instr_gnt stays 0.
REQ-042 data_req=1 (write, adr=0x200, be=4'b0011, wdata=0x1234), mem_gnt held 0 for 3 cycles while instr_req rises in cycle 2 -> mem_adr stays 0x200 until mem_gnt; data_gnt=1 is the first grant, then instr is serviced.
REQ-043 res=1 during WAIT, then mem_rvalid=1 -> instr_rvalid=0, data_rvalid=0, state IDLE.
REQ-044 Spurious mem_rvalid=1 in IDLE with no request -> no rvalid output, all outputs 0.
